// File: rtl/gobou_ctrl_pkg.sv
// Shared types, default widths and helpers for the gobou fully-connected layer sequencer.
package gobou_ctrl_pkg;
    localparam int DEF_CORE     = 16;
    localparam int DEF_DWIDTH   = 16;
    localparam int DEF_IMGSIZE  = 12;
    localparam int DEF_NETSIZE  = 14;
    localparam int DEF_LWIDTH   = 10;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_MAC_LAT  = 2;
    localparam int DEF_BIAS_LAT = 1;

    typedef enum logic [2:0] {IDLE, ACCUM, BIAS, DRAIN, WRITE, DONE} state_t;

    typedef struct packed {
        logic first;
        logic vld;
        logic last;
    } token_t;

    // Number of lanes written back for a group when rem outputs are still pending.
    function automatic int unsigned group_len(input int unsigned core, input int unsigned rem);
        return (rem < core) ? rem : core;
    endfunction

    function automatic int sel_width(input int core);
        return (core > 1) ? $clog2(core) : 1;
    endfunction
endpackage

// File: rtl/gobou_ctrl_seq_if.sv
// Host configuration/handshake plus memory and datapath control bundle of the gobou sequencer.
interface gobou_ctrl_seq_if
    import gobou_ctrl_pkg::*;
#(
    parameter int CORE    = DEF_CORE,
    parameter int IMGSIZE = DEF_IMGSIZE,
    parameter int NETSIZE = DEF_NETSIZE,
    parameter int LWIDTH  = DEF_LWIDTH
);
    localparam int SELW = sel_width(CORE);

    logic               req;
    logic               ack;
    logic               relu_en;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  total_out;
    logic [IMGSIZE-1:0] input_addr;
    logic [IMGSIZE-1:0] output_addr;
    logic [NETSIZE-1:0] net_base;
    logic [IMGSIZE-1:0] mem_img_addr;
    logic               mem_img_we;
    logic [NETSIZE-1:0] mem_net_addr;
    logic               accum_rst;
    logic               accum_we;
    logic               breg_we;
    logic               mac_oe;
    logic               bias_oe;
    logic               relu_oe;
    logic               relu_bypass;
    logic               serial_we;
    logic [SELW-1:0]    serial_sel;

    modport master (
        input  req, relu_en, total_in, total_out, input_addr, output_addr, net_base,
        output ack, mem_img_addr, mem_img_we, mem_net_addr, accum_rst, accum_we,
               breg_we, mac_oe, bias_oe, relu_oe, relu_bypass, serial_we, serial_sel
    );

    modport slave (
        output req, relu_en, total_in, total_out, input_addr, output_addr, net_base,
        input  ack, mem_img_addr, mem_img_we, mem_net_addr, accum_rst, accum_we,
               breg_we, mac_oe, bias_oe, relu_oe, relu_bypass, serial_we, serial_sel
    );
endinterface

// File: rtl/gobou_token_pipe.sv
// Fixed-depth shift of a begin/valid/end token; DEPTH=0 is a straight wire.
module gobou_token_pipe
    import gobou_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  token_t tok_in,
    output token_t tok_out
);
    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign tok_out = tok_in;
        end else begin : g_shift
            token_t stage_reg [DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
                end else begin
                    stage_reg[0] <= tok_in;
                    for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
                end
            end
            assign tok_out = stage_reg[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/gobou_ctrl_seq.sv
// Group-wise sequencer for the gobou FC layer: accumulate, bias, drain, serial write-back.
// Optional cycle counter output enabled with GOBOU_CTRL_PERF_EN.
module gobou_ctrl_seq
    import gobou_ctrl_pkg::*;
#(
    parameter int CORE     = DEF_CORE,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int IMGSIZE  = DEF_IMGSIZE,
    parameter int NETSIZE  = DEF_NETSIZE,
    parameter int LWIDTH   = DEF_LWIDTH,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int MAC_LAT  = DEF_MAC_LAT,
    parameter int BIAS_LAT = DEF_BIAS_LAT
) (
    input  logic clk,
    input  logic rst,
    gobou_ctrl_seq_if.master bus
`ifdef GOBOU_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);
    localparam int SELW = sel_width(CORE);
    localparam int CW   = LWIDTH + 1;
    localparam int unused_dwidth = DWIDTH;

    state_t             state_reg, state_next;
    logic [LWIDTH-1:0]  in_cnt_reg, in_cnt_next;
    logic [SELW-1:0]    k_reg, k_next;
    logic [CW-1:0]      out_base_reg, out_base_next;
    logic [NETSIZE-1:0] wbase_reg, wbase_next;
    logic               first_reg, first_next;
    logic [LWIDTH-1:0]  total_in_reg, total_out_reg;
    logic [IMGSIZE-1:0] input_addr_reg, output_addr_reg;
    logic               relu_bypass_reg, mac_oe_reg;
    logic               start;
    token_t             addr_tok, bias_tok, rd_tok, breg_tok, mac_tok, relu_tok;
    logic [CW-1:0]      rem, grp_len;
    logic               last_k;
    logic [IMGSIZE-1:0] img_addr;
    logic [NETSIZE-1:0] net_addr;
    logic               img_we, accum_rst, serial_we;
    logic [SELW-1:0]    serial_sel;
    logic               unused_tok;

    assign rem     = {1'b0, total_out_reg} - out_base_reg;
    assign grp_len = CW'(group_len(CORE, 32'(rem)));
    assign last_k  = (CW'(k_reg) == grp_len - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            in_cnt_reg   <= '0;
            k_reg        <= '0;
            out_base_reg <= '0;
            wbase_reg    <= '0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_cnt_reg   <= in_cnt_next;
            k_reg        <= k_next;
            out_base_reg <= out_base_next;
            wbase_reg    <= wbase_next;
            first_reg    <= first_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        in_cnt_next   = in_cnt_reg;
        k_next        = k_reg;
        out_base_next = out_base_reg;
        wbase_next    = wbase_reg;
        first_next    = first_reg;
        start         = 1'b0;
        addr_tok      = '0;
        bias_tok      = '0;
        img_addr      = '0;
        img_we        = 1'b0;
        net_addr      = '0;
        accum_rst     = 1'b0;
        serial_we     = 1'b0;
        serial_sel    = '0;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    start         = 1'b1;
                    out_base_next = '0;
                    wbase_next    = bus.net_base;
                    in_cnt_next   = '0;
                    k_next        = '0;
                    first_next    = 1'b1;
                    state_next    = (bus.total_in == '0 || bus.total_out == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // First cycle of each group only clears the lanes; addresses follow.
                if (first_reg) begin
                    accum_rst  = 1'b1;
                    first_next = 1'b0;
                end else begin
                    addr_tok.vld   = 1'b1;
                    addr_tok.first = (in_cnt_reg == '0);
                    addr_tok.last  = (in_cnt_reg == total_in_reg - LWIDTH'(1));
                    img_addr       = input_addr_reg + IMGSIZE'(in_cnt_reg);
                    net_addr       = wbase_reg + NETSIZE'(in_cnt_reg);
                    if (addr_tok.last) begin
                        in_cnt_next = '0;
                        state_next  = BIAS;
                    end else begin
                        in_cnt_next = in_cnt_reg + LWIDTH'(1);
                    end
                end
            end
            BIAS: begin
                net_addr   = wbase_reg + NETSIZE'(total_in_reg);
                bias_tok   = '{first: 1'b1, vld: 1'b1, last: 1'b1};
                state_next = DRAIN;
            end
            DRAIN: begin
                if (relu_tok.vld) begin
                    k_next     = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                serial_we  = 1'b1;
                img_we     = 1'b1;
                serial_sel = k_reg;
                img_addr   = output_addr_reg + IMGSIZE'(out_base_reg) + IMGSIZE'(k_reg);
                if (last_k) begin
                    k_next        = '0;
                    out_base_next = out_base_reg + CW'(CORE);
                    wbase_next    = wbase_reg + NETSIZE'(total_in_reg) + NETSIZE'(1);
                    first_next    = 1'b1;
                    state_next    = (out_base_reg + CW'(CORE) >= {1'b0, total_out_reg}) ? DONE : ACCUM;
                end else begin
                    k_next = k_reg + SELW'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_in_reg    <= '0;
            total_out_reg   <= '0;
            input_addr_reg  <= '0;
            output_addr_reg <= '0;
            relu_bypass_reg <= 1'b0;
        end else if (start) begin
            total_in_reg    <= bus.total_in;
            total_out_reg   <= bus.total_out;
            input_addr_reg  <= bus.input_addr;
            output_addr_reg <= bus.output_addr;
            relu_bypass_reg <= ~bus.relu_en;
        end
    end

    // mac_oe fires one cycle after the last accumulate of the group.
    always_ff @(posedge clk) begin
        if (rst) mac_oe_reg <= 1'b0;
        else     mac_oe_reg <= rd_tok.last;
    end

    gobou_token_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
        .clk(clk), .rst(rst), .tok_in(addr_tok), .tok_out(rd_tok)
    );
    gobou_token_pipe #(.DEPTH(RD_LAT)) u_breg_pipe (
        .clk(clk), .rst(rst), .tok_in(bias_tok), .tok_out(breg_tok)
    );
    gobou_token_pipe #(.DEPTH(MAC_LAT)) u_mac_pipe (
        .clk(clk), .rst(rst), .tok_in({3{mac_oe_reg}}), .tok_out(mac_tok)
    );
    gobou_token_pipe #(.DEPTH(BIAS_LAT)) u_bias_pipe (
        .clk(clk), .rst(rst), .tok_in(mac_tok), .tok_out(relu_tok)
    );

    assign unused_tok = ^{rd_tok.first, breg_tok.first, breg_tok.last,
                          mac_tok.first, mac_tok.last, relu_tok.first, relu_tok.last};

    assign bus.ack          = (state_reg == IDLE) || (state_reg == DONE);
    assign bus.mem_img_addr = img_addr;
    assign bus.mem_img_we   = img_we;
    assign bus.mem_net_addr = net_addr;
    assign bus.accum_rst    = accum_rst;
    assign bus.accum_we     = rd_tok.vld;
    assign bus.breg_we      = breg_tok.vld;
    assign bus.mac_oe       = mac_oe_reg;
    assign bus.bias_oe      = mac_tok.vld;
    assign bus.relu_oe      = relu_tok.vld;
    assign bus.relu_bypass  = relu_bypass_reg;
    assign bus.serial_we    = serial_we;
    assign bus.serial_sel   = serial_sel;

`ifdef GOBOU_CTRL_PERF_EN
    logic [31:0] cycle_cnt_reg;
    always_ff @(posedge clk) begin
        if (rst)
            cycle_cnt_reg <= '0;
        else if (start)
            cycle_cnt_reg <= '0;
        else if (state_reg != IDLE && state_reg != DONE && cycle_cnt_reg != '1)
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
    assign cycle_cnt = cycle_cnt_reg;
`endif
endmodule

// File: tb/tb_gobou_ctrl_seq.sv
// Directed bench for gobou_ctrl_seq (CORE=4, RD_LAT=1, MAC_LAT=2, BIAS_LAT=1).
module tb_gobou_ctrl_seq;
    import gobou_ctrl_pkg::*;

    localparam int CORE = 4, DWIDTH = 16, IMGSIZE = 12, NETSIZE = 14, LWIDTH = 10;
    localparam int RD_LAT = 1, MAC_LAT = 2, BIAS_LAT = 1;
    localparam int EN_ARST = 0, EN_AWE = 1, EN_BREG = 2, EN_SER = 3, EN_IWE = 4, EN_BYP = 5;

    typedef struct packed {
        logic ack, accum_rst, accum_we, breg_we, mac_oe, bias_oe, relu_oe, relu_bypass, serial_we, img_we;
        logic [IMGSIZE-1:0] img_addr;
        logic [NETSIZE-1:0] net_addr;
        logic [1:0]         sel;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    snap_t tr [64];
    snap_t s;

    always #5 clk = ~clk;

    gobou_ctrl_seq_if #(.CORE(CORE), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE), .LWIDTH(LWIDTH)) bus ();

`ifdef GOBOU_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    gobou_ctrl_seq #(
        .CORE(CORE), .DWIDTH(DWIDTH), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE), .LWIDTH(LWIDTH),
        .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT), .BIAS_LAT(BIAS_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef GOBOU_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic snap_t take();
        snap_t r;
        r.ack         = bus.ack;
        r.accum_rst   = bus.accum_rst;
        r.accum_we    = bus.accum_we;
        r.breg_we     = bus.breg_we;
        r.mac_oe      = bus.mac_oe;
        r.bias_oe     = bus.bias_oe;
        r.relu_oe     = bus.relu_oe;
        r.relu_bypass = bus.relu_bypass;
        r.serial_we   = bus.serial_we;
        r.img_we      = bus.mem_img_we;
        r.img_addr    = bus.mem_img_addr;
        r.net_addr    = bus.mem_net_addr;
        r.sel         = bus.serial_sel;
        return r;
    endfunction

    function automatic int count_en(input int which, input int lo, input int hi);
        int n = 0;
        for (int t = lo; t <= hi; t++) begin
            case (which)
                EN_ARST: n += int'(tr[t].accum_rst);
                EN_AWE:  n += int'(tr[t].accum_we);
                EN_BREG: n += int'(tr[t].breg_we);
                EN_SER:  n += int'(tr[t].serial_we);
                EN_IWE:  n += int'(tr[t].img_we);
                default: n += int'(tr[t].relu_bypass);
            endcase
        end
        return n;
    endfunction

    // Trace index 0 is the cycle right after the edge that samples req.
    task automatic start_op(input int tin, input int tout, input int ia, input int oa,
                            input int nb, input logic ren, input logic hold);
        @(posedge clk); #1;
        bus.total_in    = LWIDTH'(tin);
        bus.total_out   = LWIDTH'(tout);
        bus.input_addr  = IMGSIZE'(ia);
        bus.output_addr = IMGSIZE'(oa);
        bus.net_base    = NETSIZE'(nb);
        bus.relu_en     = ren;
        bus.req         = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.req = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            tr[t] = take();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.req = 1'b0; bus.relu_en = 1'b0; bus.total_in = '0; bus.total_out = '0;
        bus.input_addr = '0; bus.output_addr = '0; bus.net_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s = take();
        check("rst_ack", 32'(s.ack), 1);
        check("rst_enables", 32'({s.accum_rst, s.accum_we, s.breg_we, s.mac_oe, s.bias_oe,
                                  s.relu_oe, s.relu_bypass, s.serial_we, s.img_we}), 0);
        check("rst_addr", 32'({s.img_addr, s.net_addr}), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single full group: 3 inputs, 4 outputs.
        start_op(3, 4, 'h100, 'h200, 'h1000, 1'b1, 1'b0);
        capture(16);
        check("t1_accum_rst_pos", 32'(tr[0].accum_rst), 1);
        check("t1_accum_rst_cnt", count_en(EN_ARST, 0, 15), 1);
        check("t1_img_addr0", 32'(tr[1].img_addr), 'h100);
        check("t1_img_addr2", 32'(tr[3].img_addr), 'h102);
        check("t1_net_addr0", 32'(tr[1].net_addr), 'h1000);
        check("t1_bias_addr", 32'(tr[4].net_addr), 'h1003);
        check("t1_accum_we_cnt", count_en(EN_AWE, 0, 15), 3);
        check("t1_accum_we_first", 32'(tr[2].accum_we), 1);
        check("t1_breg_cnt", count_en(EN_BREG, 0, 15), 1);
        check("t1_breg_pos", 32'(tr[5].breg_we), 1);
        check("t1_mac_oe", 32'(tr[5].mac_oe), 1);
        check("t1_bias_oe", 32'(tr[7].bias_oe), 1);
        check("t1_relu_oe", 32'(tr[8].relu_oe), 1);
        check("t1_serial_cnt", count_en(EN_SER, 0, 15), 4);
        check("t1_img_we_cnt", count_en(EN_IWE, 0, 15), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_sel%0d", k), 32'(tr[9+k].sel), k);
            check($sformatf("t1_wr_addr%0d", k), 32'(tr[9+k].img_addr), 'h200 + k);
        end
        check("t1_ack_busy", 32'(tr[12].ack), 0);
        check("t1_ack_done", 32'(tr[13].ack), 1);
        check("t1_ack_idle", 32'(tr[14].ack), 1);
        check("t1_bypass", 32'(tr[5].relu_bypass), 0);

        // Two groups, second partial; ReLU bypassed.
        start_op(3, 6, 'h010, 'h040, 'h0100, 1'b0, 1'b0);
        capture(27);
        check("t2_serial_cnt", count_en(EN_SER, 0, 26), 6);
        check("t2_relu_oe", 32'(tr[8].relu_oe), 1);
        check("t2_g2_accum_rst", 32'(tr[13].accum_rst), 1);
        check("t2_g2_wbase", 32'(tr[14].net_addr), 'h104);
        check("t2_g2_bias_addr", 32'(tr[17].net_addr), 'h107);
        check("t2_g2_sel0", 32'(tr[22].sel), 0);
        check("t2_g2_sel1", 32'(tr[23].sel), 1);
        check("t2_g2_addr1", 32'(tr[23].img_addr), 'h045);
        check("t2_g2_no_third", 32'(tr[24].serial_we), 0);
        check("t2_ack_done", 32'(tr[24].ack), 1);
        check("t2_bypass_cnt", count_en(EN_BYP, 0, 24), 25);

        // Zero inputs: no activity, straight to DONE.
        start_op(0, 4, 'h100, 'h200, 'h1000, 1'b1, 1'b0);
        capture(6);
        check("t3_no_enables", count_en(EN_ARST, 0, 5) + count_en(EN_AWE, 0, 5) +
              count_en(EN_BREG, 0, 5) + count_en(EN_SER, 0, 5) + count_en(EN_IWE, 0, 5), 0);
        check("t3_ack0", 32'(tr[0].ack), 1);
        check("t3_ack1", 32'(tr[1].ack), 1);

        // Reset during WRITE, then a clean restart.
        start_op(3, 4, 'h100, 'h200, 'h1000, 1'b1, 1'b0);
        capture(10);
        check("t4_in_write", 32'(tr[9].serial_we), 1);
        rst = 1'b1;
        @(negedge clk);
        s = take();
        rst = 1'b0;
        check("t4_rst_enables", 32'({s.accum_rst, s.accum_we, s.breg_we, s.mac_oe, s.bias_oe,
                                     s.relu_oe, s.serial_we, s.img_we}), 0);
        check("t4_rst_ack", 32'(s.ack), 1);
        start_op(3, 4, 'h100, 'h200, 'h1000, 1'b1, 1'b0);
        capture(14);
        check("t4_restart_rst", 32'(tr[0].accum_rst), 1);
        check("t4_restart_ser", count_en(EN_SER, 0, 13), 4);
        check("t4_restart_ack", 32'(tr[13].ack), 1);

        // req held high; addresses wrap at 2^IMGSIZE.
        start_op(3, 2, 'hFFE, 'hFFF, 'h0200, 1'b1, 1'b1);
        capture(14);
        check("t5_wrap_in0", 32'(tr[1].img_addr), 'hFFE);
        check("t5_wrap_in2", 32'(tr[3].img_addr), 'h000);
        check("t5_wrap_out0", 32'(tr[9].img_addr), 'hFFF);
        check("t5_wrap_out1", 32'(tr[10].img_addr), 'h000);
        check("t5_serial_cnt", count_en(EN_SER, 0, 12), 2);
        check("t5_one_op", count_en(EN_ARST, 0, 12), 1);
        check("t5_ack_done", 32'(tr[11].ack), 1);
        check("t5_ack_idle", 32'(tr[12].ack), 1);
        check("t5_restart", 32'(tr[13].accum_rst), 1);
        check("t5_restart_busy", 32'(tr[13].ack), 0);
        bus.req = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_final_ack", 32'(bus.ack), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
